// File: rtl/tff_mode_counter.sv
// tff_mode_counter: WIDTH-bit toggle / prescaled up-down / load register bank with terminal-count and sticky overflow
module tff_mode_counter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1,
  parameter int SATURATE = 0
) (
  input  logic             Clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] T,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Q_b,
  output logic             tc,
  output logic             ovf
);
  typedef enum logic [1:0] {TOGGLE = 2'b00, UP = 2'b01, DOWN = 2'b10, LOAD = 2'b11} mode_e;
  mode_e            m;
  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d, ovf_q, ovf_d;
  logic             count, load, tick, at_lim, lim_step;
  assign m        = mode_e'(mode);
  assign count    = en && (m == UP || m == DOWN);
  assign load     = en && m == LOAD;
  assign at_lim   = (m == UP) ? &q_q : ~|q_q;
  assign lim_step = count && tick && at_lim;
  generate
    if (PRESCALE == 1) begin : g_nopre
      assign tick = 1'b1;
    end else begin : g_pre
      localparam int PW = $clog2(PRESCALE);
      logic [PW-1:0] pre_q, pre_d;
      assign tick = pre_q == PW'(PRESCALE - 1);
      // pre survives TOGGLE, en=0 and UP/DOWN switches; only LOAD and reset clear it
      always_comb pre_d = load ? '0 : count ? (tick ? '0 : pre_q + PW'(1)) : pre_q;
      always_ff @(posedge Clk)
        if (rst) pre_q <= '0;
        else     pre_q <= pre_d;
    end
  endgenerate
  always_comb begin
    q_d   = !en ? q_q :
            m == TOGGLE ? q_q ^ T :
            m == LOAD ? D :
            !tick || (at_lim && SATURATE != 0) ? q_q :
            m == UP ? q_q + WIDTH'(1) : q_q - WIDTH'(1);
    tc_d  = lim_step;
    ovf_d = load ? 1'b0 : (lim_step ? 1'b1 : ovf_q);
  end
  always_ff @(posedge Clk)
    if (rst) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  assign Q   = q_q;
  assign Q_b = ~q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;
endmodule

// File: tb/tb_tff_mode_counter.sv
// tb_tff_mode_counter: vector table, corner sequences and random run against a behavioural model for two configurations
module tb_tff_mode_counter;
  logic       Clk = 1'b0;
  logic       rst = 1'b1, en = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [3:0] T = '0, D = '0;
  logic [3:0] qa, qba, qb, qbb;
  logic       tca, ovfa, tcb, ovfb;
  int checks = 0, errors = 0;
  int pcfg[2] = '{3, 1};
  int scfg[2] = '{0, 1};
  int m_q[2], m_pre[2], m_tc[2], m_ovf[2];

  always #5 Clk = ~Clk;

  tff_mode_counter #(.WIDTH(4), .PRESCALE(3), .SATURATE(0)) dut_a (
    .Clk(Clk), .rst(rst), .en(en), .mode(mode), .T(T), .D(D),
    .Q(qa), .Q_b(qba), .tc(tca), .ovf(ovfa));
  tff_mode_counter #(.WIDTH(4), .PRESCALE(1), .SATURATE(1)) dut_b (
    .Clk(Clk), .rst(rst), .en(en), .mode(mode), .T(T), .D(D),
    .Q(qb), .Q_b(qbb), .tc(tcb), .ovf(ovfb));

  typedef struct {
    logic rst, en;
    logic [1:0] mode;
    logic [3:0] t, d, q;
    logic tc, ovf;
  } vec_t;
  vec_t tv[$];

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      m_tc[i] = 0;
      if (rst) begin
        m_q[i] = 0; m_pre[i] = 0; m_ovf[i] = 0;
      end else if (en) begin
        if (mode == 2'b00) m_q[i] = m_q[i] ^ int'(T);
        else if (mode == 2'b11) begin
          m_q[i] = int'(D); m_pre[i] = 0; m_ovf[i] = 0;
        end else if (m_pre[i] + 1 < pcfg[i]) m_pre[i]++;
        else begin
          int nq;
          m_pre[i] = 0;
          nq = (mode == 2'b01) ? m_q[i] + 1 : m_q[i] - 1;
          if (nq > 15 || nq < 0) begin
            m_tc[i] = 1; m_ovf[i] = 1;
            if (scfg[i] == 0) m_q[i] = (nq + 16) % 16;
          end else m_q[i] = nq;
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    model_edge();
    #1;
    check("a_q", int'(qa), m_q[0]);
    check("a_qb", int'(qba), 15 - m_q[0]);
    check("a_tc", int'(tca), m_tc[0]);
    check("a_ovf", int'(ovfa), m_ovf[0]);
    check("b_q", int'(qb), m_q[1]);
    check("b_qb", int'(qbb), 15 - m_q[1]);
    check("b_tc", int'(tcb), m_tc[1]);
    check("b_ovf", int'(ovfb), m_ovf[1]);
  endtask

  task automatic drive(input logic r, input logic e, input logic [1:0] md, input logic [3:0] t, input logic [3:0] d);
    rst = r; en = e; mode = md; T = t; D = d;
  endtask

  task automatic b_expect(input string name, input int q, input int t, input int o);
    check({name, "_q"}, int'(qb), q);
    check({name, "_tc"}, int'(tcb), t);
    check({name, "_ovf"}, int'(ovfb), o);
  endtask

  initial begin
    // dut_a (PRESCALE=3, wrap): reset, toggle, load+up wrap, en gating, reset mid-prescale, pre carry up->down
    tv.push_back('{1, 0, 2'b00, 4'h0, 4'h0, 4'h0, 0, 0});
    tv.push_back('{1, 1, 2'b01, 4'h0, 4'h0, 4'h0, 0, 0});
    tv.push_back('{0, 1, 2'b00, 4'hA, 4'h0, 4'hA, 0, 0});
    tv.push_back('{0, 1, 2'b00, 4'hA, 4'h0, 4'h0, 0, 0});
    tv.push_back('{0, 1, 2'b00, 4'hA, 4'h0, 4'hA, 0, 0});
    tv.push_back('{0, 1, 2'b11, 4'h0, 4'hE, 4'hE, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'hE, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'hE, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'hF, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'hF, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'hF, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'h0, 1, 1});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'h0, 0, 1});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'h0, 0, 1});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'h1, 0, 1});
    tv.push_back('{0, 1, 2'b11, 4'h0, 4'h0, 4'h0, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'h0, 0, 0});
    tv.push_back('{0, 0, 2'b01, 4'h0, 4'h0, 4'h0, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'h0, 0, 0});
    tv.push_back('{0, 0, 2'b01, 4'h0, 4'h0, 4'h0, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'h1, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'h1, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'h1, 0, 0});
    tv.push_back('{1, 1, 2'b01, 4'h0, 4'h0, 4'h0, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'h0, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'h0, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'h1, 0, 0});
    tv.push_back('{0, 1, 2'b11, 4'h0, 4'h0, 4'h0, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'h0, 0, 0});
    tv.push_back('{0, 1, 2'b01, 4'h0, 4'h0, 4'h0, 0, 0});
    tv.push_back('{0, 1, 2'b10, 4'h0, 4'h0, 4'hF, 1, 1});
    tv.push_back('{0, 0, 2'b10, 4'h0, 4'h0, 4'hF, 0, 1});
    foreach (tv[k]) begin
      drive(tv[k].rst, tv[k].en, tv[k].mode, tv[k].t, tv[k].d);
      cyc();
      check($sformatf("vec%0d_q", k), int'(qa), int'(tv[k].q));
      check($sformatf("vec%0d_tc", k), int'(tca), int'(tv[k].tc));
      check($sformatf("vec%0d_ovf", k), int'(ovfa), int'(tv[k].ovf));
    end
    // dut_b (PRESCALE=1, saturate): repeated underflow pulses, en=0 kills tc, load clears ovf
    drive(0, 1, 2'b11, 4'h0, 4'h1); cyc(); b_expect("sat_load1", 1, 0, 0);
    drive(0, 1, 2'b10, 4'h0, 4'h0); cyc(); b_expect("sat_dn1", 0, 0, 0);
    cyc(); b_expect("sat_dn2", 0, 1, 1);
    cyc(); b_expect("sat_dn3", 0, 1, 1);
    cyc(); b_expect("sat_dn4", 0, 1, 1);
    drive(0, 0, 2'b10, 4'h0, 4'h0); cyc(); b_expect("sat_hold", 0, 0, 1);
    drive(0, 1, 2'b11, 4'h0, 4'h5); cyc(); b_expect("sat_load5", 5, 0, 0);
    drive(0, 1, 2'b11, 4'h0, 4'hF); cyc(); b_expect("sat_loadF", 15, 0, 0);
    drive(0, 1, 2'b01, 4'h0, 4'h0); cyc(); b_expect("sat_up", 15, 1, 1);
    drive(0, 1, 2'b00, 4'hF, 4'h0); cyc(); b_expect("tog_inv", 0, 0, 1);
    // random traffic with rare resets
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 40) == 0, $urandom_range(0, 5) != 0, 2'($urandom_range(0, 3)),
            4'($urandom), 4'($urandom));
      cyc();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
